adc128s_model: RTL and testbench
================================

Name: adc128s_model

Overview:
- Behavioural-synthesizable model of an 8-channel, 12-bit ADC128S-style SPI A2D converter, used in the Segway system bench.
- The Segway controller's A2D interface polls it for left load cell, right load cell and battery voltage.
- The bench sets the three analogue values as 12-bit digital inputs.
- The model answers SPI frames with the value of the channel addressed in the previous frame.

Parameters:
- LFT_CH, 0, channel number that returns lft_cell_set.
- RGHT_CH, 4, channel number that returns rght_cell_set.
- BATT_CH, 5, channel number that returns batt_set.

Ports:
- clk  input  1  system clock; all logic runs on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  SPI slave select, active low; frames one transaction.
- SCLK  input  1  SPI serial clock from the master (mode 0).
- MOSI  input  1  SPI command data from the master.
- MISO  output  1  SPI response data; high-Z while SS_n high.
- lft_cell_set  input  12  conversion value for LFT_CH.
- rght_cell_set  input  12  conversion value for RGHT_CH.
- batt_set  input  12  conversion value for BATT_CH.

Behaviour:
- Input sync: SS_n, SCLK and MOSI are double-flopped on clk. SCLK rise and fall are edge-detected from the synced copies.
  - Master must hold SCLK high and low for at least 4 clk each.
- Frame: 16 bits, MSB first.
  - Starts on the synced SS_n fall and ends on the synced SS_n rise.
  - MOSI is sampled on each SCLK rise into a 16-bit rx shift register.
  - Command format: bits[13:11] = channel address; all other bits are don't-care.
- Response load: on the SS_n fall, the tx shift register loads {4'h0, value(prev_ch)}.
  - value() selects lft_cell_set, rght_cell_set or batt_set per the parameters.
  - Any other channel returns 12'h000.
  - Set inputs are sampled only at this instant; later changes do not affect the frame in progress.
- MISO output:
  - MISO = tx[15] while SS_n is low.
  - tx shifts left by one on each SCLK fall that follows at least one SCLK rise in the frame.
  - The first bit is valid before the first SCLK rise.
  - MISO updates within 3 clk of the physical SCLK fall.
- Pipelining: on the SS_n rise, if exactly 16 SCLK rises were counted, prev_ch <= rx[13:11].
  - A frame of any other length leaves prev_ch unchanged.
  - The bit counter (5 bits) saturates at 31.
- Reset values (async, rst_n low):
  - prev_ch = LFT_CH; rx = 0; tx = 0; bit count = 0.
  - Sync flops = idle (SS_n = 1, SCLK = 0).
  - MISO high-Z.
- Reset mid-frame: the frame is abandoned.
  - After reset releases, the model waits for a fresh SS_n fall.
  - An SS_n already low at release is not treated as a frame start.
- Simultaneous events:
  - SS_n rise with a pending SCLK edge: the frame end wins and no shift occurs.
  - SS_n fall on the same clk as an SCLK edge: the load wins.
- Back-to-back frames: SS_n high for a minimum of 4 clk between frames.

Optional Feature:
- Macro ADC128S_FRAME_CHECK_EN.
- When defined, the module adds output frame_err (1 bit, reset 0). frame_err is sticky and is cleared only by reset.
- frame_err sets on any SS_n rise where the SCLK rise count is not 16, or where rx[15:14] is nonzero.
- When frame_err sets, the model issues a $display warning showing the bit count and the rx word.
- When the macro is undefined, the port and check logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then frame with cmd 16'h2000 (ch4), lft_cell_set = 12'h205 -> MISO returns 16'h0205 (prev_ch reset = 0).
- Next frame with cmd 16'h2800 (ch5), rght_cell_set = 12'h1A3 -> returns 16'h01A3.
- Next frame with cmd 16'h0000, batt_set = 12'h0FF -> returns 16'h00FF; a following frame returns lft_cell_set.
- Command ch7, then another frame -> returns 16'h0000.
- Abort a ch5 command after 9 bits (SS_n high), then send a full frame -> response uses the channel from before the aborted frame; with the macro defined, frame_err = 1.
- Change batt_set mid-frame and assert rst_n low mid-frame -> the current response is unchanged by the batt_set change; after reset MISO is high-Z, prev_ch = 0, and the next frame returns lft_cell_set.

Source files
------------

// File: rtl/adc128s_model.sv
// adc128s_model: behavioural-synthesizable model of an 8-channel, 12-bit
// ADC128S-style SPI A2D converter (SPI mode 0, 16-bit frames, MSB first).
// Each frame returns the conversion value of the channel addressed in the
// previous complete frame. SS_n, SCLK and MOSI are oversampled on clk.
// Optional feature: define ADC128S_FRAME_CHECK_EN to add the sticky
// frame_err output. It flags frames that are not exactly 16 bits long or
// that carry nonzero command bits [15:14].
module adc128s_model #(
  parameter logic [2:0] LFT_CH  = 3'd0,
  parameter logic [2:0] RGHT_CH = 3'd4,
  parameter logic [2:0] BATT_CH = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
`ifdef ADC128S_FRAME_CHECK_EN
  output logic        frame_err,
`endif
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set,
  input  logic [11:0] batt_set
);

  // ARM waits after reset until SS_n is seen idle (high), so a select that
  // is already low at reset release never starts a frame.
  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_FRAME} state_t;

`ifdef ADC128S_FRAME_CHECK_EN
  localparam int RX_W = 16;
`else
  // Bits 15:14 of the command are only ever looked at by the frame check.
  localparam int RX_W = 14;
`endif

  logic            ss_n_meta, ss_n_sync;
  logic            sclk_meta, sclk_sync, sclk_prev;
  logic            mosi_meta, mosi_sync;
  logic            sclk_rise, sclk_fall;

  state_t          state;
  logic [1:0]      settle;
  logic [2:0]      prev_ch;
  logic [RX_W-1:0] rx;
  logic [15:0]     tx;
  logic [4:0]      bit_cnt;
  logic [11:0]     load_val;

  // Double-flop the asynchronous SPI inputs and keep one extra SCLK stage
  // for edge detection; reset values correspond to an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_meta <= 1'b1;
      ss_n_sync <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns this chain into a real shift pipeline.
      ss_n_meta <= SS_n;
      ss_n_sync <= ss_n_meta;
      sclk_meta <= SCLK;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= MOSI;
      mosi_sync <= mosi_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_prev;
  assign sclk_fall = ~sclk_sync & sclk_prev;

  // Conversion value of the channel addressed by the previous frame.
  always_comb begin
    // NOTE: the default assignment up front guarantees every path writes
    // load_val, so no latch can be inferred for unmatched channels.
    load_val = 12'h000;
    if (prev_ch == LFT_CH)
      load_val = lft_cell_set;
    else if (prev_ch == RGHT_CH)
      load_val = rght_cell_set;
    else if (prev_ch == BATT_CH)
      load_val = batt_set;
  end

  // Frame sequencer: arm after reset, load on select, shift on SCLK edges,
  // latch the next channel on a clean 16-bit frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ARM;
      settle  <= 2'd0;
      prev_ch <= LFT_CH;
      rx      <= '0;
      tx      <= '0;
      bit_cnt <= '0;
`ifdef ADC128S_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        // Two clocks flush the reset values out of the synchroniser; only
        // then is ss_n_sync a true sample of SS_n.
        ST_ARM: begin
          if (settle != 2'd2)
            settle <= settle + 2'd1;
          else if (ss_n_sync)
            state <= ST_IDLE;
        end
        // The select fall takes priority over any coincident SCLK edge.
        ST_IDLE: begin
          if (!ss_n_sync) begin
            tx      <= {4'h0, load_val};
            bit_cnt <= 5'd0;
            state   <= ST_FRAME;
          end
        end
        // The select rise takes priority over any pending SCLK edge.
        ST_FRAME: begin
          if (ss_n_sync) begin
            if (bit_cnt == 5'd16)
              prev_ch <= rx[13:11];
`ifdef ADC128S_FRAME_CHECK_EN
            if (bit_cnt != 5'd16 || rx[15:14] != 2'b00) begin
              frame_err <= 1'b1;
              $display("adc128s_model warning: bad frame, bit count=%0d rx=%h",
                       bit_cnt, rx);
            end
`endif
            state <= ST_IDLE;
          end else if (sclk_rise) begin
            rx <= {rx[RX_W-2:0], mosi_sync};
            if (bit_cnt != 5'd31)
              bit_cnt <= bit_cnt + 5'd1;
          end else if (sclk_fall && bit_cnt != 5'd0) begin
            tx <= {tx[14:0], 1'b0};
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  // MISO is driven only inside an active frame.
  assign MISO = (state == ST_FRAME) ? tx[15] : 1'bz;

endmodule

// File: tb/tb_adc128s_model.sv
// tb_adc128s_model: self-checking bench for adc128s_model. A channel-to-value
// reference model predicts each frame's response from the previously
// addressed channel; MISO sits on a pulled-up net so an undriven line reads 1.
module tb_adc128s_model;

  localparam logic [2:0] LFT_CH  = 3'd0;
  localparam logic [2:0] RGHT_CH = 3'd4;
  localparam logic [2:0] BATT_CH = 3'd5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n  = 1'b1;
  logic        sclk  = 1'b0;
  logic        mosi  = 1'b0;
  logic [11:0] lft   = 12'h000;
  logic [11:0] rght  = 12'h000;
  logic [11:0] batt  = 12'h000;
  wire         miso;
`ifdef ADC128S_FRAME_CHECK_EN
  logic        frame_err;
`endif

  pullup (miso);

  int          checks   = 0;
  int          failures = 0;
  logic [2:0]  model_prev = LFT_CH;

  always #5 clk = ~clk;

  adc128s_model #(.LFT_CH(LFT_CH), .RGHT_CH(RGHT_CH), .BATT_CH(BATT_CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (ss_n),
    .SCLK         (sclk),
    .MOSI         (mosi),
    .MISO         (miso),
`ifdef ADC128S_FRAME_CHECK_EN
    .frame_err    (frame_err),
`endif
    .lft_cell_set (lft),
    .rght_cell_set(rght),
    .batt_set     (batt)
  );

  // Reference: the response word for a given previously addressed channel.
  function automatic logic [15:0] expected_word(input logic [2:0] ch);
    if (ch == LFT_CH)       return {4'h0, lft};
    else if (ch == RGHT_CH) return {4'h0, rght};
    else if (ch == BATT_CH) return {4'h0, batt};
    else                    return 16'h0000;
  endfunction

  task automatic frame_begin();
    @(negedge clk) ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // One SPI bit: MISO is sampled just before the SCLK rise, as a mode-0
  // master would.
  task automatic frame_bit(input logic b, output logic r);
    mosi = b;
    repeat (6) @(negedge clk);
    r = miso;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Full or partial frame; only the first 16 response bits are returned.
  task automatic run_frame(input logic [15:0] cmd, input int nbits,
                           output logic [15:0] resp);
    logic r;
    logic [15:0] c;
    resp = 16'h0000;
    c = cmd;
    frame_begin();
    for (int i = 0; i < nbits; i++) begin
      frame_bit((i < 16) ? c[15 - i] : 1'b0, r);
      if (i < 16) resp[15 - i] = r;
    end
    frame_end();
    if (nbits == 16) model_prev = c[13:11];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (miso !== 1'b1) begin
      failures++;
      $display("FAIL reset_miso_hiz: got %b required 1 (undriven)", miso);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (miso !== 1'b1) begin
      failures++;
      $display("FAIL idle_miso_hiz: got %b required 1 (undriven)", miso);
    end
`ifdef ADC128S_FRAME_CHECK_EN
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_err: got %b required 0", frame_err);
    end
`endif
  endtask

  task automatic test_channels();
    logic [15:0] resp;
    lft  = 12'h205;
    rght = 12'h1A3;
    batt = 12'h0FF;
    run_frame(16'h2000, 16, resp);
    checks++;
    if (resp !== 16'h0205) begin
      failures++;
      $display("FAIL first_frame_lft: got %h required 0205", resp);
    end
    run_frame(16'h2800, 16, resp);
    checks++;
    if (resp !== 16'h01A3) begin
      failures++;
      $display("FAIL ch4_rght: got %h required 01a3", resp);
    end
    run_frame(16'h3800, 16, resp);
    checks++;
    if (resp !== 16'h00FF) begin
      failures++;
      $display("FAIL ch5_batt: got %h required 00ff", resp);
    end
    run_frame(16'h0000, 16, resp);
    checks++;
    if (resp !== 16'h0000) begin
      failures++;
      $display("FAIL ch7_zero: got %h required 0000", resp);
    end
    run_frame(16'h0000, 16, resp);
    checks++;
    if (resp !== 16'h0205) begin
      failures++;
      $display("FAIL ch0_lft: got %h required 0205", resp);
    end
    checks++;
    if (miso !== 1'b1) begin
      failures++;
      $display("FAIL between_frames_hiz: got %b required 1 (undriven)", miso);
    end
  endtask

  task automatic test_abort();
    logic [15:0] resp;
    logic [15:0] exp;
    exp = expected_word(model_prev);
    run_frame(16'h2800, 9, resp);
    exp = expected_word(model_prev);
    run_frame(16'h2000, 16, resp);
    checks++;
    if (resp !== exp) begin
      failures++;
      $display("FAIL abort_keeps_ch: got %h required %h", resp, exp);
    end
`ifdef ADC128S_FRAME_CHECK_EN
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL abort_frame_err: got %b required 1", frame_err);
    end
`endif
  endtask

  // 48 SCLK rises: a wrapping 5-bit counter would land on 16 and wrongly
  // accept the frame.
  task automatic test_long_frame();
    logic [15:0] resp;
    logic [15:0] exp;
    exp = expected_word(model_prev);
    run_frame(16'h3800, 48, resp);
    checks++;
    if (resp !== exp) begin
      failures++;
      $display("FAIL long_frame_resp: got %h required %h", resp, exp);
    end
    exp = expected_word(model_prev);
    run_frame(16'h0000, 16, resp);
    checks++;
    if (resp !== exp) begin
      failures++;
      $display("FAIL long_frame_keeps_ch: got %h required %h", resp, exp);
    end
  endtask

  task automatic test_random();
    logic [15:0] resp;
    logic [15:0] exp;
    logic [15:0] cmd;
    for (int n = 0; n < 12; n++) begin
      lft  = 12'($urandom);
      rght = 12'($urandom);
      batt = 12'($urandom);
      cmd  = {2'b00, 3'($urandom_range(0, 7)), 11'($urandom)};
      exp  = expected_word(model_prev);
      run_frame(cmd, 16, resp);
      checks++;
      if (resp !== exp) begin
        failures++;
        $display("FAIL random_frame_%0d: got %h required %h", n, resp, exp);
      end
    end
  endtask

  task automatic test_batt_change();
    logic [15:0] resp;
    logic [15:0] exp;
    logic [15:0] c;
    logic r;
    run_frame(16'h2800, 16, resp);
    exp = expected_word(model_prev);
    c = 16'h2800;
    frame_begin();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) batt = ~batt;
      frame_bit(c[15 - i], r);
      resp[15 - i] = r;
    end
    frame_end();
    model_prev = c[13:11];
    checks++;
    if (resp !== exp) begin
      failures++;
      $display("FAIL batt_change_mid_frame: got %h required %h", resp, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] resp;
    logic [15:0] exp;
    logic [15:0] c;
    logic r;
    resp = 16'h0000;
    exp = expected_word(model_prev);
    c = 16'h2000;
    frame_begin();
    for (int i = 0; i < 6; i++) begin
      frame_bit(c[15 - i], r);
      resp[15 - i] = r;
    end
    checks++;
    if (resp[15:10] !== exp[15:10]) begin
      failures++;
      $display("FAIL pre_reset_bits: got %b required %b", resp[15:10], exp[15:10]);
    end
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (miso !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_reset_hiz: got %b required 1 (undriven)", miso);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (miso !== 1'b1) begin
      failures++;
      $display("FAIL low_ss_at_release_hiz: got %b required 1 (undriven)", miso);
    end
`ifdef ADC128S_FRAME_CHECK_EN
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_after_reset: got %b required 0", frame_err);
    end
`endif
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    model_prev = LFT_CH;
    exp = expected_word(model_prev);
    run_frame(16'h2800, 16, resp);
    checks++;
    if (resp !== exp) begin
      failures++;
      $display("FAIL post_reset_lft: got %h required %h", resp, exp);
    end
  endtask

  initial begin
    test_reset();
    test_channels();
    test_abort();
    test_long_frame();
    test_random();
    test_batt_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
